nios_ii_debug_po_adc_channel_ctrl: RTL and testbench

NIOS_II_DEBUG_PO_ADC_CHANNEL_CTRL -- requirements
Module: nios_ii_debug_po_adc_channel_ctrl

---
 rtl/nios_ii_debug_pio_pkg.sv | 13 +
 rtl/nios_ii_debug_pulse_gen.sv | 23 ++
 rtl/nios_ii_debug_po_adc_channel_ctrl.sv | 83 ++++++++
 tb/tb_nios_ii_debug_po_adc_channel_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nios_ii_debug_pio_pkg.sv
// Shared register map for the debug PIO family, plus the pulse counter width helper.
package nios_ii_debug_pio_pkg;
   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_OUT    = 3'd1;
   localparam logic [2:0] ADDR_STROBE = 3'd2;
   localparam logic [2:0] ADDR_PLEN   = 3'd3;
   localparam logic [2:0] ADDR_OUTSET = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR = 3'd5;

   function automatic int cnt_width(input int plen);
      return $clog2(plen + 1);
   endfunction
endpackage

// File: rtl/nios_ii_debug_pulse_gen.sv
// One-shot strobe: a down-counter loaded on trigger, strobe high while nonzero.
module nios_ii_debug_pulse_gen
   import nios_ii_debug_pio_pkg::*;
#(
   parameter int PULSE_LEN = 8,
   parameter int CNT_W     = cnt_width(PULSE_LEN)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_trig,
   output logic o_strobe
);
   logic [CNT_W-1:0] r_cnt;

   // A trigger while the counter is running is dropped, so pulses never stretch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                      r_cnt <= '0;
      else if (i_trig && r_cnt == '0)    r_cnt <= CNT_W'(PULSE_LEN);
      else if (r_cnt != '0)              r_cnt <= r_cnt - 1'b1;
   end

   assign o_strobe = (r_cnt != '0);
endmodule

// File: rtl/nios_ii_debug_po_adc_channel_ctrl.sv
// Avalon-MM output port with per-bit one-shot strobes for ADC channel control.
// Define PO_ADC_CHANNEL_CTRL_SETCLR_EN to enable outset (addr 4) / outclear (addr 5).
module nios_ii_debug_po_adc_channel_ctrl
   import nios_ii_debug_pio_pkg::*;
#(
   parameter int               WIDTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               PULSE_LEN   = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [WIDTH-1:0]  out_port,
   output logic [WIDTH-1:0]  strobe,
   output logic              busy
);
   logic [WIDTH-1:0] r_data;
   logic [31:0]      r_readdata;
   logic [31:0]      w_rd_next;
   logic [WIDTH-1:0] w_wd;
   logic [WIDTH-1:0] w_trig;
   logic [WIDTH-1:0] w_strobe;
   logic             w_wr;

   assign w_wr   = chipselect & ~write_n;
   assign w_wd   = writedata[WIDTH-1:0];
   assign w_trig = (w_wr && address == ADDR_STROBE) ? w_wd : '0;

   if (WIDTH < 32) begin : g_unused_wd
      logic w_unused;
      assign w_unused = ^writedata[31:WIDTH];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data <= RESET_VALUE;
      end else if (w_wr) begin
         case (address)
            ADDR_DATA:   r_data <= w_wd;
`ifdef PO_ADC_CHANNEL_CTRL_SETCLR_EN
            ADDR_OUTSET: r_data <= r_data | w_wd;
            ADDR_OUTCLR: r_data <= r_data & ~w_wd;
`endif
            default:     r_data <= r_data;
         endcase
      end
   end

   // Reads are not qualified by chipselect; the mux follows address every cycle.
   always_comb begin
      w_rd_next = '0;
      case (address)
         ADDR_DATA:   w_rd_next = 32'(r_data);
         ADDR_OUT:    w_rd_next = 32'(r_data);
         ADDR_STROBE: w_rd_next = 32'(w_strobe);
         ADDR_PLEN:   w_rd_next = 32'(PULSE_LEN);
         default:     w_rd_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_readdata <= '0;
      else          r_readdata <= w_rd_next;
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_pulse
      nios_ii_debug_pulse_gen #(.PULSE_LEN(PULSE_LEN)) u_pulse (
         .clk      (clk),
         .reset_n  (reset_n),
         .i_trig   (w_trig[g]),
         .o_strobe (w_strobe[g])
      );
   end

   assign readdata = r_readdata;
   assign out_port = r_data;
   assign strobe   = w_strobe;
   assign busy     = |w_strobe;
endmodule

// File: tb/tb_nios_ii_debug_po_adc_channel_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a timestamp-based model.
module tb_nios_ii_debug_po_adc_channel_ctrl;
   localparam int             W    = 4;
   localparam int             PLEN = 8;
   localparam logic [W-1:0]   RV   = '0;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic [2:0]    address = '0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [31:0]   readdata;
   logic [W-1:0]  out_port;
   logic [W-1:0]  strobe;
   logic          busy;

   int checks = 0;
   int failures = 0;

   // Model: each pulse is remembered by the edge index that started it.
   int            cyc = 0;
   int            start_q[W];
   logic [W-1:0]  m_data;
   logic [31:0]   m_rd;

   nios_ii_debug_po_adc_channel_ctrl #(.WIDTH(W), .RESET_VALUE(RV), .PULSE_LEN(PLEN)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .out_port(out_port), .strobe(strobe), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] m_strobe(input int n);
      logic [W-1:0] s = '0;
      for (int i = 0; i < W; i++)
         if (n >= start_q[i] && n < start_q[i] + PLEN) s[i] = 1'b1;
      return s;
   endfunction

   task automatic model_reset;
      m_data = RV;
      m_rd   = '0;
      for (int i = 0; i < W; i++) start_q[i] = -100000;
   endtask

   // Drive one bus cycle from a negedge, update the model, return at the next negedge.
   task automatic step(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
      logic [W-1:0] cur;
      address = a; chipselect = cs; write_n = wn; writedata = wd;
      cur = m_strobe(cyc);
      case (a)
         3'd0, 3'd1: m_rd = 32'(m_data);
         3'd2:       m_rd = 32'(cur);
         3'd3:       m_rd = PLEN;
         default:    m_rd = '0;
      endcase
      if (cs && !wn) begin
         case (a)
            3'd0: m_data = wd[W-1:0];
            3'd2: for (int i = 0; i < W; i++) if (wd[i] && !cur[i]) start_q[i] = cyc + 1;
`ifdef PO_ADC_CHANNEL_CTRL_SETCLR_EN
            3'd4: m_data = m_data | wd[W-1:0];
            3'd5: m_data = m_data & ~wd[W-1:0];
`endif
            default: ;
         endcase
      end
      @(posedge clk); cyc++;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic idle;
      step(3'd7, 1'b0, 1'b1, 32'h0);
   endtask

   // Assert reset mid-cycle, hold two edges, release just after a negedge.
   task automatic assert_reset;
      #2 reset_n = 1'b0;
      #1 model_reset();
   endtask

   task automatic release_reset;
      @(posedge clk); cyc++;
      @(posedge clk); cyc++;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      assert_reset();
      checks++; if (out_port !== RV) begin failures++; $display("FAIL reset_out_port got=%h exp=%h", out_port, RV); end
      checks++; if (strobe !== '0) begin failures++; $display("FAIL reset_strobe got=%h exp=0", strobe); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
      release_reset();
      checks++; if (out_port !== RV) begin failures++; $display("FAIL post_reset_out got=%h exp=%h", out_port, RV); end
   endtask

   task automatic test_data_write;
      step(3'd0, 1'b1, 1'b0, 32'hFFFF_FFF5);
      checks++; if (out_port !== 4'h5) begin failures++; $display("FAIL data_out_port got=%h exp=5", out_port); end
      step(3'd0, 1'b1, 1'b1, 32'h0);
      checks++; if (readdata !== 32'h0000_0005) begin failures++; $display("FAIL data_readback got=%h exp=00000005", readdata); end
      step(3'd3, 1'b0, 1'b1, 32'h0);
      checks++; if (readdata !== 32'(PLEN)) begin failures++; $display("FAIL plen_readback got=%h exp=%h", readdata, PLEN); end
      step(3'd6, 1'b1, 1'b0, 32'hA);
      step(3'd1, 1'b1, 1'b0, 32'hC);
      step(3'd1, 1'b1, 1'b1, 32'h0);
      checks++; if (out_port !== 4'h5 || readdata !== 32'h5) begin
         failures++; $display("FAIL noop_writes out=%h rd=%h exp=5/5", out_port, readdata);
      end
   endtask

   task automatic test_strobe_pulse;
      int hi = 0;
      int busy_hi = 0;
      step(3'd2, 1'b1, 1'b0, 32'h3);
      for (int k = 0; k < PLEN + 4; k++) begin
         if (strobe === 4'h3) hi++;
         if (busy === 1'b1) busy_hi++;
         if (k == 1) begin
            address = 3'd2;
            @(posedge clk); cyc++; @(negedge clk);
            checks++; if (readdata !== 32'h3) begin failures++; $display("FAIL strobe_readback got=%h exp=3", readdata); end
         end else idle();
      end
      checks++; if (hi != PLEN) begin failures++; $display("FAIL pulse_len got=%0d exp=%0d", hi, PLEN); end
      checks++; if (busy_hi != PLEN) begin failures++; $display("FAIL busy_len got=%0d exp=%0d", busy_hi, PLEN); end
      checks++; if (strobe !== '0 || busy !== 1'b0) begin failures++; $display("FAIL pulse_end strobe=%h busy=%b exp=0/0", strobe, busy); end
   endtask

   task automatic test_no_retrigger;
      int hi = 1;
      step(3'd2, 1'b1, 1'b0, 32'h1);
      idle(); idle(); hi += 2;
      step(3'd2, 1'b1, 1'b0, 32'h1);
      for (int k = 0; k < PLEN + 4; k++) begin
         if (strobe[0] === 1'b1) hi++;
         idle();
      end
      checks++; if (hi != PLEN) begin failures++; $display("FAIL retrigger_len got=%0d exp=%0d", hi, PLEN); end
   endtask

   task automatic test_reset_mid_pulse;
      int seen = 0;
      step(3'd0, 1'b1, 1'b0, 32'h6);
      step(3'd2, 1'b1, 1'b0, 32'h1);
      idle(); idle(); idle();
      checks++; if (strobe !== 4'h1) begin failures++; $display("FAIL mid_pulse_active got=%h exp=1", strobe); end
      assert_reset();
      checks++; if (strobe !== '0 || busy !== 1'b0) begin failures++; $display("FAIL reset_abort strobe=%h busy=%b exp=0/0", strobe, busy); end
      checks++; if (out_port !== RV) begin failures++; $display("FAIL reset_abort_out got=%h exp=%h", out_port, RV); end
      release_reset();
      for (int k = 0; k < PLEN + 2; k++) begin
         if (strobe !== '0) seen++;
         idle();
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL pulse_resumed cycles=%0d exp=0", seen); end
   endtask

   task automatic test_setclr;
      logic [W-1:0] e1, e2;
`ifdef PO_ADC_CHANNEL_CTRL_SETCLR_EN
      e1 = 4'hB; e2 = 4'h3;
`else
      e1 = 4'h9; e2 = 4'h9;
`endif
      step(3'd0, 1'b1, 1'b0, 32'h9);
      step(3'd4, 1'b1, 1'b0, 32'h2);
      checks++; if (out_port !== e1) begin failures++; $display("FAIL outset got=%h exp=%h", out_port, e1); end
      step(3'd5, 1'b1, 1'b0, 32'h8);
      checks++; if (out_port !== e2) begin failures++; $display("FAIL outclear got=%h exp=%h", out_port, e2); end
      step(3'd4, 1'b0, 1'b1, 32'h0);
      checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL outset_read got=%h exp=0", readdata); end
   endtask

   task automatic test_random;
      for (int k = 0; k < 400; k++) begin
         step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, $urandom());
         checks++; if (out_port !== m_data) begin failures++; $display("FAIL rand_out k=%0d got=%h exp=%h", k, out_port, m_data); end
         checks++; if (strobe !== m_strobe(cyc)) begin failures++; $display("FAIL rand_strobe k=%0d got=%h exp=%h", k, strobe, m_strobe(cyc)); end
         checks++; if (busy !== (|m_strobe(cyc))) begin failures++; $display("FAIL rand_busy k=%0d got=%b exp=%b", k, busy, |m_strobe(cyc)); end
         checks++; if (readdata !== m_rd) begin failures++; $display("FAIL rand_readdata k=%0d got=%h exp=%h", k, readdata, m_rd); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_data_write();
      test_strobe_pulse();
      test_no_retrigger();
      test_reset_mid_pulse();
      test_setclr();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
